burst_rr_arb: RTL
=================

# burst_rr_arb

Round-robin, burst-locking arbiter that shares one output port of the request crossbar among N requesters. It adds three things to the plain per-port arbitration stage:
- multi-beat bursts delivered without interleaving;
- fairness, by advancing the round-robin pointer per completed burst;
- a one-entry registered output stage with a source-ID tag, plus a sticky protocol-error flag for overlong bursts.

It sits between the per-input select logic and one crossbar output.

## Interface
- N, 8, number of requesters (≥2)
- PLD_WIDTH, 32, payload width
- MAX_BURST, 16, beat count at which an unterminated burst is flagged (≥2)
- SRC_W, $clog2(N), width of out_src (derived, not overridden)

Ports:
- clk  in  1  clock; single clock domain, all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_vld  in  N  per-requester beat valid
- in_pld  in  PLD_WIDTH×[N-1:0]  per-requester payload (unpacked array)
- in_last  in  N  beat is final of burst
- in_rdy  out  N  per-requester beat accepted this cycle when paired with in_vld
- out_vld  out  1  output stage holds a beat
- out_pld  out  PLD_WIDTH  registered payload
- out_last  out  1  registered last flag
- out_src  out  SRC_W  index of requester that supplied the beat
- out_rdy  in  1  downstream accepts beat
- busy  out  1  state==LOCKED or out_vld
- err_burst  out  1  sticky overlong-burst flag
- err_clr  in  1  clears err_burst

## Operation
- Definitions:
  - can_acc = !out_vld || out_rdy
  - acc = in_vld[g] && in_rdy[g]
- State machine, two states:
  - IDLE: grant g = first i with in_vld[i], searching ptr, ptr+1, … N-1, 0, … ptr-1 (mod N).
  - LOCKED: g = lock_id, regardless of other valids.
- in_rdy[i] = can_acc && (i==g) && (IDLE ? any in_vld : 1). At most one in_rdy bit is high per cycle.
- On acc, the output register loads pld=in_pld[g], last=in_last[g], src=g, and out_vld=1.
- Output drain: when out_vld && out_rdy && !acc, out_vld→0 and data registers hold their values.
- Transitions:
  - IDLE, acc, last=0 → LOCKED, lock_id=g, beat_cnt=1.
  - IDLE, acc, last=1 → stay IDLE, ptr=(g+1) mod N.
  - LOCKED, acc, last=0 → stay LOCKED, beat_cnt+1 (saturating at MAX_BURST).
  - LOCKED, acc, last=1 → IDLE, ptr=(lock_id+1) mod N, beat_cnt=0.
  - No acc → state, ptr, lock_id and beat_cnt hold.
- ptr changes only on an accepted last beat. Wrap: g=N-1 gives ptr=0.
- In LOCKED, lock_id's in_vld low is a bubble: no grant moves, and other requesters stay stalled.
- Overlong burst: in LOCKED, an acc with last=0 while beat_cnt==MAX_BURST-1 sets err_burst (1 cycle after the beat). The burst continues and the lock is kept.
- err_clr clears err_burst; when set and clear coincide, set wins.
- Requesters must hold in_vld/in_pld/in_last stable until accepted. In IDLE, g may change between cycles while nothing is accepted (new higher-priority valid).

## Timing
- Reset values: out_vld=0, out_pld=0, out_last=0, out_src=0, err_burst=0, busy=0, state=IDLE, ptr=0, lock_id=0, beat_cnt=0.
- A reset mid-burst drops the lock and any held beat immediately.
- Latency: beat accepted in cycle t appears on out_* in t+1.
- Throughput: 1 beat/cycle sustained while out_rdy=1. Accept and drain may occur in the same cycle.
- Combinational paths:
  - in_vld → in_rdy (IDLE grant)
  - out_rdy → in_rdy
  - None from in_pld to any output.
- Backpressure: out_vld=1 && out_rdy=0 forces all in_rdy=0. out_* stay stable until out_rdy.
- Single-beat bursts (last=1 in IDLE) never enter LOCKED.

## Test plan
- Reset mid-burst:
  - Stimulus: requester 2 sends 3 beats of a 5-beat burst, then rst_n=0 for 1 cycle.
  - Required: all outputs at reset values next cycle, busy=0, and ptr=0 (requester 0 wins next if valid).
- All 8 valid, single-beat, out_rdy=1:
  - Stimulus: every requester presents single-beat bursts continuously.
  - Required: out_src sequence 0,1,…,7,0 on consecutive cycles, out_vld continuous from cycle 1.
- Burst lock:
  - Stimulus: requester 3 sends 4 beats (last on beat 4) while requester 1 is continuously valid.
  - Required: out_src=3 for 4 consecutive beats, then 1. in_rdy[1]=0 throughout the burst.
- Backpressure:
  - Stimulus: out_rdy=0 for 3 cycles with a beat held.
  - Required: out_pld/out_src stable, in_rdy=0. The beat is released on the out_rdy=1 cycle, and a new beat is accepted in that same cycle.
- Overlong burst and wrap:
  - Stimulus (MAX_BURST=4): requester 7 sends 6 beats, last on 6.
  - Required: err_burst rises the cycle after beat 4 is accepted and stays high. After the burst, ptr=0. err_clr asserted alone clears it.
- Bubble in lock:
  - Stimulus: requester 5 is in LOCKED and drops in_vld for 2 cycles while requester 6 is valid.
  - Required: no beat from 6 is accepted until 5 sends last.

Source files
------------

// File: rtl/burst_rr_arb.sv
// Round-robin arbiter that locks the grant for the length of a multi-beat burst.
// It feeds one registered output stage tagged with the source index.
//
// state  | meaning
// IDLE   | no burst open; the grant rotates from ptr among the valid requesters
// LOCKED | burst from lock_id in progress; every other requester is stalled
module burst_rr_arb #(
  parameter int N         = 8,
  parameter int PLD_WIDTH = 32,
  parameter int MAX_BURST = 16,
  localparam int SRC_W    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_vld,
  input  logic [PLD_WIDTH-1:0] in_pld [N-1:0],
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_rdy,
  output logic                 out_vld,
  output logic [PLD_WIDTH-1:0] out_pld,
  output logic                 out_last,
  output logic [SRC_W-1:0]     out_src,
  input  logic                 out_rdy,
  output logic                 busy,
  output logic                 err_burst,
  input  logic                 err_clr
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] lock_id;
  logic [CNT_W-1:0] beat_cnt;

  logic [SRC_W-1:0] idle_gnt;
  logic [SRC_W-1:0] gnt;
  logic [SRC_W-1:0] next_ptr;
  logic             any_vld;
  logic             locked;
  logic             can_acc;
  logic             gnt_ok;
  logic             acc;
  logic             sel_last;
  logic             err_set;

  // Requester with the smallest rotational distance from ptr wins.
  always_comb begin
    int d;
    int best_d;
    idle_gnt = '0;
    any_vld  = 1'b0;
    best_d   = N;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(ptr)) % N;
      if (in_vld[i] && d < best_d) begin
        best_d   = d;
        idle_gnt = SRC_W'(i);
        any_vld  = 1'b1;
      end
    end
  end

  assign locked   = (state == ST_LOCKED);
  assign can_acc  = !out_vld || out_rdy;
  assign gnt      = locked ? lock_id : idle_gnt;
  assign gnt_ok   = locked || any_vld;

  always_comb begin
    in_rdy = '0;
    if (can_acc && gnt_ok) in_rdy[gnt] = 1'b1;
  end

  assign acc      = |(in_rdy & in_vld);
  assign sel_last = in_last[gnt];
  assign next_ptr = (gnt == SRC_W'(N - 1)) ? '0 : gnt + SRC_W'(1);
  assign err_set  = locked && acc && !sel_last && (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign busy     = locked || out_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      lock_id   <= '0;
      beat_cnt  <= '0;
      out_vld   <= 1'b0;
      out_pld   <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      err_burst <= 1'b0;
    end else begin
      if (acc) begin
        out_vld  <= 1'b1;
        out_pld  <= in_pld[gnt];
        out_last <= sel_last;
        out_src  <= gnt;
        if (!locked) begin
          if (sel_last) begin
            ptr <= next_ptr;
          end else begin
            state    <= ST_LOCKED;
            lock_id  <= gnt;
            beat_cnt <= CNT_W'(1);
          end
        end else if (sel_last) begin
          state    <= ST_IDLE;
          ptr      <= next_ptr;
          beat_cnt <= '0;
        end else if (beat_cnt != CNT_W'(MAX_BURST)) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end

      // A new overlong beat outranks a clear in the same cycle.
      if (err_set)      err_burst <= 1'b1;
      else if (err_clr) err_burst <= 1'b0;
    end
  end

endmodule
